// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared definitions for the run-control sequencer that sits in front of the
// 9-bit core datapath.
//   - run_state_e : sequencer states (INIT, CLEAR, HOLD, ARMED, RUN, DONE)
//   - DEF_*       : default parameter values for run_controller
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

    localparam int DEF_DM_DEPTH   = 256;     // data-memory words to clear
    localparam int DEF_DM_AW      = 8;       // data-memory address width
    localparam int DEF_CNT_W      = 32;      // cycle counter width
    localparam int DEF_MAX_CYCLES = 100000;  // RUN-cycle watchdog limit

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_HOLD  = 3'd2,
        ST_ARMED = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } run_state_e;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at all-ones instead of wrapping, with a
// terminal-match flag against a compare value.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear to 0 (priority over enable)
//   enable     : count up by one this cycle (holds at all-ones)
//   compare    : value to match against
//   count      : current count
//   match      : count == compare (combinational)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] compare,
    output logic [WIDTH-1:0] count,
    output logic             match
);

    // NOTE: sequential state is assigned with <= so every flop samples
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign match = (count == compare);

endmodule

// File: rtl/run_controller.sv
// -----------------------------------------------------------------------------
// run_controller
// Run-control sequencer for the 9-bit core. Converts the bench start/done
// handshake into a core clear pulse, an optional data-memory clear walk and a
// per-cycle run enable; reports done, watchdog timeout and RUN-cycle count.
//
// Build option: define RUN_CTRL_MEM_CLEAR_EN to include the CLEAR state that
// zeroes data memory before every program. Without it INIT goes straight to
// HOLD and the memory-clear outputs are tied to 0 (memory may be preloaded).
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   start         : bench start level (rise arms, fall launches, high in
//                   RUN aborts, high in DONE restarts)
//   halt_req      : decoder halt, combinational from the current instruction
//   core_clr      : clear PC and register file (high while in INIT)
//   run_en        : core may advance PC / commit writes this cycle
//   mem_clr_we    : data-memory clear write strobe (write data is 0)
//   mem_clr_addr  : data-memory clear address
//   done          : program finished (registered)
//   timeout       : program ended by watchdog rather than halt
//   cycle_count   : RUN cycles of the last or current program (saturating)
// -----------------------------------------------------------------------------
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int DM_DEPTH   = DEF_DM_DEPTH,
    parameter int DM_AW      = DEF_DM_AW,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    output logic             core_clr,
    output logic             run_en,
    output logic             mem_clr_we,
    output logic [DM_AW-1:0] mem_clr_addr,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    // Count value seen during the last permitted RUN cycle.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    run_state_e state;
    logic       cnt_clear;
    logic       cnt_en;
    logic       wd_hit;

    assign cnt_clear = (state == ST_INIT);
    assign cnt_en    = (state == ST_RUN);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .compare (WD_LAST),
        .count   (cycle_count),
        .match   (wd_hit)
    );

`ifdef RUN_CTRL_MEM_CLEAR_EN
    localparam logic [DM_AW-1:0] LAST_ADDR = DM_AW'(DM_DEPTH - 1);
    logic [DM_AW-1:0] clr_addr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            done     <= 1'b0;
            timeout  <= 1'b0;
`ifdef RUN_CTRL_MEM_CLEAR_EN
            clr_addr <= '0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    done     <= 1'b0;
                    timeout  <= 1'b0;
`ifdef RUN_CTRL_MEM_CLEAR_EN
                    clr_addr <= '0;
                    state    <= ST_CLEAR;
`else
                    state    <= ST_HOLD;
`endif
                end
`ifdef RUN_CTRL_MEM_CLEAR_EN
                ST_CLEAR: begin
                    // start is deliberately ignored until the walk completes.
                    if (clr_addr == LAST_ADDR) begin
                        clr_addr <= '0;
                        state    <= ST_HOLD;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
`endif
                ST_HOLD: begin
                    if (start) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!start) state <= ST_RUN;
                end
                ST_RUN: begin
                    // Abort beats completion; halt beats the watchdog.
                    if (start) begin
                        state <= ST_INIT;
                    end else if (halt_req) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                    end else if (wd_hit) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // done/timeout drop as INIT is entered so INIT never
                    // shows a stale result.
                    if (start) begin
                        state   <= ST_INIT;
                        done    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign core_clr = (state == ST_INIT);
    // The halting instruction itself never advances the PC or commits.
    assign run_en   = (state == ST_RUN) && !halt_req;

`ifdef RUN_CTRL_MEM_CLEAR_EN
    assign mem_clr_we   = (state == ST_CLEAR);
    assign mem_clr_addr = clr_addr;
`else
    assign mem_clr_we   = 1'b0;
    assign mem_clr_addr = '0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// -----------------------------------------------------------------------------
// tb_run_controller
// Self-checking bench for run_controller (DM_DEPTH=256, MAX_CYCLES=20).
// Works with RUN_CTRL_MEM_CLEAR_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_run_controller;
    import run_ctrl_pkg::*;

    localparam int DM_DEPTH = 256;
    localparam int DM_AW    = 8;
    localparam int CNT_W    = 32;
    localparam int MAXC     = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             halt_req;
    logic             core_clr;
    logic             run_en;
    logic             mem_clr_we;
    logic [DM_AW-1:0] mem_clr_addr;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    run_controller #(
        .DM_DEPTH   (DM_DEPTH),
        .DM_AW      (DM_AW),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .halt_req     (halt_req),
        .core_clr     (core_clr),
        .run_en       (run_en),
        .mem_clr_we   (mem_clr_we),
        .mem_clr_addr (mem_clr_addr),
        .done         (done),
        .timeout      (timeout),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic start;
        logic halt;
        logic core_clr;
        logic run_en;
        logic done;
        logic timeout;
        logic chk_cnt;
        int   cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock, then drive this cycle's inputs; outputs are
    // sampled 1 ns later, well clear of both clock edges.
    task automatic cyc(input logic s, input logic h);
        @(posedge clk);
        #1;
        start    = s;
        halt_req = h;
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic h, input logic cc,
                                input logic re, input logic d, input logic to,
                                input logic ck, input int n);
        vec_t v;
        v.start = s; v.halt = h; v.core_clr = cc; v.run_en = re;
        v.done = d; v.timeout = to; v.chk_cnt = ck; v.cnt = n;
        return v;
    endfunction

    // Precondition: the current cycle is INIT. Ends in the first HOLD cycle.
    task automatic walk_to_hold(input string tag);
`ifdef RUN_CTRL_MEM_CLEAR_EN
        for (int i = 0; i < DM_DEPTH; i++) begin
            // start held high during CLEAR must be ignored
            cyc(i < DM_DEPTH - 1, 1'b0);
            check($sformatf("%s clr_we[%0d]", tag, i), 32'(mem_clr_we), 1);
            check($sformatf("%s clr_addr[%0d]", tag, i), 32'(mem_clr_addr), i);
            check($sformatf("%s clr_run_en[%0d]", tag, i), 32'(run_en | core_clr | done), 0);
        end
`endif
        cyc(1'b0, 1'b0);
        check({tag, " hold_we"}, 32'(mem_clr_we), 0);
        check({tag, " hold_addr"}, 32'(mem_clr_addr), 0);
        check({tag, " hold_core_clr"}, 32'(core_clr), 0);
        check({tag, " hold_run_en"}, 32'(run_en), 0);
        check({tag, " hold_done"}, 32'(done), 0);
        check({tag, " hold_cnt"}, cycle_count, 0);
    endtask

    // Precondition: in HOLD. Runs one program; halt_at/abort_at of 0 = never.
    task automatic run_prog(input string tag, input int start_len, input int halt_at,
                            input int abort_at, input logic exp_to, input int exp_cnt);
        for (int i = 0; i < start_len; i++) begin
            cyc(1'b1, 1'b0);
            check($sformatf("%s start_run_en[%0d]", tag, i), 32'(run_en), 0);
        end
        cyc(1'b0, 1'b0);
        check({tag, " armed_run_en"}, 32'(run_en), 0);
        for (int c = 1; c <= MAXC; c++) begin
            cyc(c == abort_at, c == halt_at);
            check($sformatf("%s run_en[%0d]", tag, c), 32'(run_en), 32'(c != halt_at));
            check($sformatf("%s run_done[%0d]", tag, c), 32'(done), 0);
            check($sformatf("%s run_cnt[%0d]", tag, c), cycle_count, c - 1);
            if (c == halt_at || c == abort_at) break;
        end
        cyc(1'b0, 1'b0);
        if (abort_at != 0) begin
            check({tag, " abort_core_clr"}, 32'(core_clr), 1);
            check({tag, " abort_done"}, 32'(done), 0);
            check({tag, " abort_run_en"}, 32'(run_en), 0);
        end else begin
            check({tag, " done"}, 32'(done), 1);
            check({tag, " timeout"}, 32'(timeout), 32'(exp_to));
            check({tag, " cnt"}, cycle_count, exp_cnt);
            check({tag, " done_run_en"}, 32'(run_en), 0);
            cyc(1'b0, 1'b1);
            check({tag, " done_held"}, 32'(done), 1);
            check({tag, " cnt_held"}, cycle_count, exp_cnt);
            check({tag, " halt_in_done_run_en"}, 32'(run_en), 0);
        end
    endtask

    // Precondition: in DONE. Ends in the INIT cycle.
    task automatic restart(input string tag);
        cyc(1'b1, 1'b0);
        check({tag, " pre_done"}, 32'(done), 1);
        cyc(1'b0, 1'b0);
        check({tag, " init_core_clr"}, 32'(core_clr), 1);
        check({tag, " init_done"}, 32'(done), 0);
        check({tag, " init_timeout"}, 32'(timeout), 0);
        check({tag, " init_run_en"}, 32'(run_en), 0);
        check({tag, " init_we"}, 32'(mem_clr_we), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " core_clr"}, 32'(core_clr), 1);
        check({tag, " run_en"}, 32'(run_en), 0);
        check({tag, " we"}, 32'(mem_clr_we), 0);
        check({tag, " addr"}, 32'(mem_clr_addr), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " timeout"}, 32'(timeout), 0);
        check({tag, " cnt"}, cycle_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        walk_to_hold("boot");

        // Program 1 (table): start high 5 cycles, halt on RUN cycle 10.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 9; k++) vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, k - 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 9));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 10));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 10));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 10));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].start, vecs[i].halt);
            check($sformatf("vec%0d core_clr", i), 32'(core_clr), 32'(vecs[i].core_clr));
            check($sformatf("vec%0d run_en", i), 32'(run_en), 32'(vecs[i].run_en));
            check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
            check($sformatf("vec%0d timeout", i), 32'(timeout), 32'(vecs[i].timeout));
            if (vecs[i].chk_cnt)
                check($sformatf("vec%0d cnt", i), cycle_count, vecs[i].cnt);
        end
        walk_to_hold("p1");

        run_prog("p2", 1, 3, 0, 1'b0, 3);
        restart("r2");
        walk_to_hold("r2");

        run_prog("wd", 2, 0, 0, 1'b1, MAXC);
        restart("r3");
        walk_to_hold("r3");

        run_prog("wd_halt", 1, MAXC, 0, 1'b0, MAXC);
        restart("r4");
        walk_to_hold("r4");

        run_prog("abort", 1, 0, 4, 1'b0, 0);
        walk_to_hold("abort");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0);
            check($sformatf("abort idle_done[%0d]", i), 32'(done), 0);
        end

        // Asynchronous reset mid-operation.
`ifdef RUN_CTRL_MEM_CLEAR_EN
        run_prog("p5", 1, 2, 0, 1'b0, 2);
        restart("r5");
        for (int i = 0; i <= 100; i++) cyc(1'b0, 1'b0);
        check("mid_clear addr", 32'(mem_clr_addr), 100);
        reset = 1'b1;
        #1;
        check_reset_vals("mid_clear_reset");
`else
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("mid_run run_en", 32'(run_en), 1);
        check("mid_run cnt", cycle_count, 1);
        reset = 1'b1;
        #1;
        check_reset_vals("mid_run_reset");
`endif
        reset = 1'b0;
        walk_to_hold("post_reset");
        run_prog("p6", 1, 5, 0, 1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
